// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, LSB first,
// one bit per clock, with borrow/overflow/zero flags registered at completion.
module serial_subtractor #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] shadow;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             ai;
  logic             bi;
  logic             d;
  logic             br_nxt;
  logic             last;
  logic [WIDTH-1:0] shadow_nxt;

  // One full-subtractor slice on the current LSBs
  always_comb begin
    ai         = a_sr[0];
    bi         = b_sr[0];
    d          = ai ^ bi ^ br;
    br_nxt     = (~ai & bi) | (~(ai ^ bi) & br);
    shadow_nxt = {d, shadow[WIDTH-1:1]};
    last       = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      shadow   <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= borrow_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= br_nxt;
          shadow <= shadow_nxt;
          cnt    <= cnt + CW'(1);
          // Final slice sees the operand MSBs, so signed overflow is taken here
          if (last) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            diff     <= shadow_nxt;
            borrow   <= br_nxt;
            overflow <= (ai ^ bi) & (d ^ ai);
            zero     <= (shadow_nxt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed 8-bit vectors plus a
// 32-bit random run checked against 33-bit arithmetic.
module tb_serial_subtractor;

  typedef struct packed {
    logic [63:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk;
  int   checks;
  int   errors;

  logic       rst8, start8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, borrow8, ovf8, zero8;
  logic [7:0] diff8;

  logic        rst32, start32, bin32;
  logic [31:0] a32, b32;
  logic        busy32, done32, borrow32, ovf32, zero32;
  logic [31:0] diff32;

  exp_t q8[$];
  exp_t q32[$];
  logic [7:0]  held8;
  logic [31:0] held32;
  logic        rst8_q, rst32_q;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst8), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8),
    .overflow(ovf8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(32)) u32 (
    .clk(clk), .reset(rst32), .start(start32), .a(a32), .b(b32), .borrow_in(bin32),
    .busy(busy32), .done(done32), .diff(diff32), .borrow(borrow32),
    .overflow(ovf32), .zero(zero32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    rst8_q  <= rst8;
    rst32_q <= rst32;
  end

  // Monitors: pop expected result on every done, otherwise diff must hold
  always @(negedge clk) begin
    exp_t e;
    if (rst8_q) begin
      held8 = diff8;
    end else if (done8) begin
      chk("done8_expected", 64'(q8.size() > 0), 64'd1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("diff8", 64'(diff8), e.diff);
        chk("borrow8", 64'(borrow8), 64'(e.borrow));
        chk("overflow8", 64'(ovf8), 64'(e.ovf));
        chk("zero8", 64'(zero8), 64'(e.zero));
      end
      held8 = diff8;
    end else begin
      chk("diff8_stable", 64'(diff8), 64'(held8));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst32_q) begin
      held32 = diff32;
    end else if (done32) begin
      chk("done32_expected", 64'(q32.size() > 0), 64'd1);
      if (q32.size() > 0) begin
        e = q32.pop_front();
        chk("diff32", 64'(diff32), e.diff);
        chk("borrow32", 64'(borrow32), 64'(e.borrow));
        chk("overflow32", 64'(ovf32), 64'(e.ovf));
        chk("zero32", 64'(zero32), 64'(e.zero));
      end
      held32 = diff32;
    end else begin
      chk("diff32_stable", 64'(diff32), 64'(held32));
    end
  end

  task automatic push8(input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
    exp_t e;
    e.diff   = 64'(ed);
    e.borrow = eb;
    e.ovf    = eo;
    e.zero   = ez;
    q8.push_back(e);
  endtask

  // Single 8-bit operation; optional stray start with junk operands during RUN
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bin,
                     input logic [7:0] ed, input logic eb, input logic eo,
                     input logic ez, input logic poke);
    int n;
    push8(ed, eb, eo, ez);
    a8 = av; b8 = bv; bin8 = bin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("busy_after_accept", 64'(busy8), 64'd1);
    n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
      end else if (poke && n == 4) begin
        start8 = 1'b0;
      end
    end
    chk("latency8", 64'(n), 64'd8);
  endtask

  task automatic op32(input logic [31:0] av, input logic [31:0] bv, input logic bin);
    logic [32:0] full;
    exp_t        e;
    int          n;
    full     = {1'b0, av} - {1'b0, bv} - 33'(bin);
    e.diff   = 64'(full[31:0]);
    e.borrow = full[32];
    e.ovf    = (av[31] != bv[31]) && (full[31] != av[31]);
    e.zero   = (full[31:0] == 32'd0);
    q32.push_back(e);
    a32 = av; b32 = bv; bin32 = bin; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    a32 = ~av; b32 = ~bv;
    n = 0;
    while (!done32 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency32", 64'(n), 64'd32);
  endtask

  logic [7:0] b2b_a [4] = '{8'h10, 8'h00, 8'h80, 8'hC0};
  logic [7:0] b2b_b [4] = '{8'h01, 8'h01, 8'h80, 8'h40};
  logic [7:0] b2b_d [4] = '{8'h0F, 8'hFF, 8'h00, 8'h80};
  logic       b2b_br[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic       b2b_z [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int n;
    checks = 0; errors = 0;
    held8 = '0; held32 = '0;
    rst8 = 1'b1; rst32 = 1'b1;
    start8 = 1'b0; start32 = 1'b0;
    a8 = '0; b8 = '0; bin8 = 1'b0;
    a32 = '0; b32 = '0; bin32 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_diff", 64'(diff8), 64'd0);
    chk("rst_flags", 64'({borrow8, ovf8, zero8}), 64'd0);
    chk("rst_diff32", 64'(diff32), 64'd0);
    rst8 = 1'b0; rst32 = 1'b0;
    @(posedge clk); #1;

    // Directed arithmetic vectors
    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
    op8(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    op8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    // Stray start and operand changes during RUN must not matter
    op8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back with start held high: done every 9 cycles
    start8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push8(b2b_d[i], b2b_br[i], 1'b0, b2b_z[i]);
      a8 = b2b_a[i]; b8 = b2b_b[i]; bin8 = 1'b0;
      @(posedge clk); #1;
      a8 = 8'hA5; b8 = 8'h3C;
      repeat (8) @(posedge clk);
      #1;
      chk("b2b_done", 64'(done8), 64'd1);
    end
    start8 = 1'b0;

    // Leaves nonzero diff and flags so the reset check below is meaningful
    op8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset in RUN cycle 4 abandons the operation
    a8 = 8'h44; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    chk("midrst_busy", 64'(busy8), 64'd0);
    chk("midrst_done", 64'(done8), 64'd0);
    chk("midrst_diff", 64'(diff8), 64'd0);
    chk("midrst_flags", 64'({borrow8, ovf8, zero8}), 64'd0);
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) n++;
    end
    chk("midrst_no_done", 64'(n), 64'd0);
    op8(8'h20, 8'h30, 1'b1, 8'hEF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset and start on the same edge: request dropped
    rst8 = 1'b1; start8 = 1'b1; a8 = 8'h09; b8 = 8'h02;
    @(posedge clk); #1;
    rst8 = 1'b0; start8 = 1'b0;
    chk("rst_start_busy", 64'(busy8), 64'd0);
    @(posedge clk); #1;
    chk("rst_start_busy2", 64'(busy8), 64'd0);

    // 32-bit random run
    op32(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    op32(32'h00000000, 32'hFFFFFFFF, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      op32($urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
